// File: rtl/grad_seq_player.sv
// ============================================================================
// Module   : grad_seq_player
// Brief    : Timed playback of a stored 32-bit word sequence onto per-channel
//            emit strobes, with per-word hold counts, optional looping,
//            busy-error counting and a sticky data-lost flag.
//            CHANNELS is meaningful in the range 1..4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grad_seq_player #(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  mem_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] mem_wr_addr_i,
  input  logic [31:0]           mem_wr_data_i,
  input  logic [ADDR_WIDTH-1:0] offset_i,
  input  logic                  data_enb_i,
  input  logic                  loop_i,
  input  logic [15:0]           interval_i,
  input  logic [CHANNELS-1:0]   chan_mask_i,
  input  logic                  serial_busy_i,
  input  logic                  data_lost_i,
  input  logic                  err_clr_i,
  output logic [23:0]           data_o,
  output logic [CHANNELS-1:0]   valid_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ERR_WIDTH-1:0]  busy_err_o,
  output logic                  data_lost_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  // Fields of the word currently held, captured in LOAD
  logic                  end_flag;
  logic [1:0]            chan;
  logic [23:0]           payload;
  logic [4:0]            hold_cnt;

  logic [15:0]           timer;
  logic [15:0]           period_m1;
  logic                  slot;

  logic                  load_timer;
  logic                  capture;
  logic                  dec_hold;
  logic                  emit;
  logic                  chan_ok;
  logic                  emit_send;
  logic                  busy_inc;
  logic [CHANNELS-1:0]   valid_nxt;

  // Slot period is never shorter than 4 cycles so a fetch always completes
  // between two consecutive slots.
  assign period_m1 = ((interval_i < 16'd4) ? 16'd4 : interval_i) - 16'd1;
  assign slot      = (state == ST_RUN) && (timer == 16'd0);
  assign chan_ok   = (int'(chan) < CHANNELS);
  assign emit_send = emit && chan_ok && !serial_busy_i;
  assign busy_inc  = emit && chan_ok && serial_busy_i;

  // Sequence memory: host write port plus registered read of rd_addr (read-first)
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_wr_en_i) begin
      mem[mem_wr_addr_i] <= mem_wr_data_i;
    end
    rd_word <= mem[rd_addr];
  end

  // State register
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    state_nxt  = state;
    addr_nxt   = rd_addr;
    load_timer = 1'b0;
    capture    = 1'b0;
    dec_hold   = 1'b0;
    emit       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_enb_i) begin
          state_nxt  = ST_FETCH;
          addr_nxt   = offset_i;
          load_timer = 1'b1;
        end
      end
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        capture   = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (slot) begin
          if (hold_cnt != 5'd0) begin
            dec_hold = 1'b1;
          end else begin
            emit = 1'b1;
            if (!end_flag) begin
              addr_nxt  = rd_addr + ADDR_WIDTH'(1);
              state_nxt = ST_FETCH;
            end else if (loop_i) begin
              addr_nxt  = offset_i;
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
    // Dropping the enable aborts from any state without emitting
    if (!data_enb_i) begin
      state_nxt  = ST_IDLE;
      addr_nxt   = rd_addr;
      load_timer = 1'b0;
      dec_hold   = 1'b0;
      emit       = 1'b0;
    end
  end

  // One-hot emit strobe gated by the channel mask
  always_comb begin
    valid_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      valid_nxt[i] = emit_send && (int'(chan) == i) && chan_mask_i[i];
    end
  end

  // Slot timer: counts down while a sequence is active, reloading each slot
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      timer <= '0;
    end else if (load_timer) begin
      timer <= period_m1;
    end else if (state == ST_FETCH || state == ST_LOAD || state == ST_RUN) begin
      timer <= (timer == 16'd0) ? period_m1 : timer - 16'd1;
    end else begin
      timer <= '0;
    end
  end

  // Read address and captured word fields
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_addr  <= '0;
      end_flag <= 1'b0;
      chan     <= '0;
      payload  <= '0;
      hold_cnt <= '0;
    end else begin
      rd_addr <= addr_nxt;
      if (capture) begin
        end_flag <= rd_word[31];
        hold_cnt <= rd_word[30:26];
        chan     <= rd_word[25:24];
        payload  <= rd_word[23:0];
      end else if (dec_hold) begin
        hold_cnt <= hold_cnt - 5'd1;
      end
    end
  end

  // Emit outputs: data_o only changes on a non-suppressed emit
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      valid_o <= '0;
      data_o  <= '0;
    end else begin
      valid_o <= valid_nxt;
      if (emit_send) begin
        data_o <= payload;
      end
    end
  end

  // Saturating busy-error counter; a clear coincident with an increment yields 1
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      busy_err_o <= '0;
    end else if (err_clr_i) begin
      busy_err_o <= busy_inc ? ERR_WIDTH'(1) : '0;
    end else if (busy_inc && !(&busy_err_o)) begin
      busy_err_o <= busy_err_o + ERR_WIDTH'(1);
    end
  end

  // Sticky data-lost flag, set wins over clear
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      data_lost_o <= 1'b0;
    end else if (data_lost_i) begin
      data_lost_o <= 1'b1;
    end else if (err_clr_i) begin
      data_lost_o <= 1'b0;
    end
  end

  assign done_o    = (state == ST_DONE);
  assign rd_addr_o = rd_addr;

endmodule

`default_nettype wire

// File: tb/tb_grad_seq_player.sv
// ============================================================================
// Module   : tb_grad_seq_player
// Brief    : Self-checking bench for grad_seq_player: table vectors, directed
//            sequences and randomized runs against a slot-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_grad_seq_player;

  localparam int CH    = 3;
  localparam int AW    = 6;
  localparam int EW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int MAXH  = 2100;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW-1:0] offset;
  logic          enb;
  logic          loop_en;
  logic [15:0]   interval;
  logic [CH-1:0] mask;
  logic          busy;
  logic          lost;
  logic          clr;
  logic [23:0]   data_o;
  logic [CH-1:0] valid_o;
  logic          done_o;
  logic [AW-1:0] rd_addr_o;
  logic [EW-1:0] busy_err_o;
  logic          data_lost_o;

  grad_seq_player #(.CHANNELS(CH), .ADDR_WIDTH(AW), .ERR_WIDTH(EW)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .mem_wr_en_i  (wr_en),
    .mem_wr_addr_i(wr_addr),
    .mem_wr_data_i(wr_data),
    .offset_i     (offset),
    .data_enb_i   (enb),
    .loop_i       (loop_en),
    .interval_i   (interval),
    .chan_mask_i  (mask),
    .serial_busy_i(busy),
    .data_lost_i  (lost),
    .err_clr_i    (clr),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .done_o       (done_o),
    .rd_addr_o    (rd_addr_o),
    .busy_err_o   (busy_err_o),
    .data_lost_o  (data_lost_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   t;
    logic [CH-1:0] v;
    logic [23:0]   d;
    logic [AW-1:0] a;
  } ev_t;

  typedef struct {
    int            h;
    int            c;
    logic [23:0]   pay;
    bit            bsy;
    logic [CH-1:0] msk;
    int            intv;
    int            t;
    logic [CH-1:0] ev;
    logic [23:0]   ed;
    int            ee;
  } row_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_mem [DEPTH];
  bit          busy_tab [MAXH];
  bit          clr_tab  [MAXH];
  ev_t         obs_q[$];
  ev_t         exp_q[$];
  logic [23:0] start_data;
  int          start_err;
  logic [23:0] exp_data;
  int          exp_err;
  bit          exp_done;
  row_t        rows [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input bit e, input int h, input int c, input logic [23:0] p);
    logic [4:0] hh;
    logic [1:0] cc;
    hh = h[4:0];
    cc = c[1:0];
    return {e, hh, cc, p};
  endfunction

  task automatic write_word(input int addr, input logic [31:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = w;
    model_mem[addr] = w;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < MAXH; i++) begin
      busy_tab[i] = 1'b0;
      clr_tab[i]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enb = 1'b0;
    busy = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    start_data = '0;
    start_err  = 0;
  endtask

  // Walk the stored words slot by slot: word k is emitted H slots after the
  // previous emit, slot s lands (s+1)*P cycles after enable, and busy is the
  // value presented in the cycle just before that slot boundary.
  task automatic compute_model(input int horizon);
    int          p, s, t, addr, nxt, c, e;
    logic [31:0] w;
    logic [CH-1:0] oh;
    ev_t         ev;
    bit          inc_at [MAXH+1];
    for (int i = 0; i <= MAXH; i++) inc_at[i] = 1'b0;
    exp_q.delete();
    exp_data = start_data;
    exp_done = 1'b0;
    p = (int'(interval) < 4) ? 4 : int'(interval);
    addr = int'(offset);
    s = 0;
    while (1) begin
      w = model_mem[addr];
      s = s + int'(w[30:26]);
      t = (s + 1) * p;
      if (t > horizon) break;
      if (!w[31])       nxt = (addr + 1) % DEPTH;
      else if (loop_en) nxt = int'(offset);
      else              nxt = addr;
      c = int'(w[25:24]);
      if (c < CH) begin
        if (busy_tab[t-1]) begin
          inc_at[t] = 1'b1;
        end else begin
          exp_data = w[23:0];
          if (mask[c]) begin
            oh = '0;
            oh[c] = 1'b1;
            ev.t = t[15:0];
            ev.v = oh;
            ev.d = w[23:0];
            ev.a = nxt[AW-1:0];
            exp_q.push_back(ev);
          end
        end
      end
      if (w[31] && !loop_en) begin
        exp_done = 1'b1;
        break;
      end
      addr = nxt;
      s++;
    end
    e = start_err;
    for (int r = 0; r < horizon; r++) begin
      if (clr_tab[r])                                   e = inc_at[r+1] ? 1 : 0;
      else if (inc_at[r+1] && e < (1 << EW) - 1)        e = e + 1;
    end
    exp_err = e;
  endtask

  // Enable playback, record emits for horizon cycles, compare with the model
  task automatic run_scenario(input int horizon);
    ev_t ev;
    int  n;
    compute_model(horizon);
    obs_q.delete();
    @(negedge clk);
    rst  = 1'b0;
    enb  = 1'b1;
    busy = 1'b0;
    clr  = 1'b0;
    for (int r = 0; r <= horizon; r++) begin
      @(negedge clk);
      if (valid_o != '0) begin
        ev.t = r[15:0];
        ev.v = valid_o;
        ev.d = data_o;
        ev.a = rd_addr_o;
        obs_q.push_back(ev);
      end
      if (r < horizon) begin
        busy = busy_tab[r];
        clr  = clr_tab[r];
      end
    end
    busy = 1'b0;
    clr  = 1'b0;
    check("emit_count", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("emit%0d{t,v,d,a}", i), 64'(obs_q[i]), 64'(exp_q[i]));
    end
    check("data_end", 64'(data_o), 64'(exp_data));
    check("busy_err_end", 64'(busy_err_o), 64'(exp_err));
    check("done_end", 64'(done_o), 64'(exp_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(valid_o), 64'(0));
    check({tag, "_data"}, 64'(data_o), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(0));
    check({tag, "_rd_addr"}, 64'(rd_addr_o), 64'(0));
    check({tag, "_busy_err"}, 64'(busy_err_o), 64'(0));
    check({tag, "_lost"}, 64'(data_lost_o), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_valid;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; offset = '0;
    enb = 1'b0; loop_en = 1'b0; interval = 16'd4; mask = '1;
    busy = 1'b0; lost = 1'b0; clr = 1'b0;
    start_data = '0; start_err = 0;
    clear_tabs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Single-word vectors: {H, C, payload, busy, mask, interval, emit time,
    // expected valid, expected data, expected busy_err}
    rows[0] = '{0,  0, 24'hABCDEF, 1'b0, 3'b111, 0, 4,   3'b001, 24'hABCDEF, 0};
    rows[1] = '{2,  1, 24'h123456, 1'b0, 3'b111, 5, 15,  3'b010, 24'h123456, 0};
    rows[2] = '{0,  2, 24'h0F0F0F, 1'b0, 3'b011, 4, 4,   3'b000, 24'h0F0F0F, 0};
    rows[3] = '{1,  2, 24'h555555, 1'b1, 3'b111, 3, 8,   3'b000, 24'h000000, 1};
    rows[4] = '{0,  3, 24'h777777, 1'b1, 3'b111, 6, 6,   3'b000, 24'h000000, 0};
    rows[5] = '{31, 0, 24'hC0FFEE, 1'b0, 3'b111, 4, 128, 3'b001, 24'hC0FFEE, 0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      write_word(10, mkw(1'b1, rows[i].h, rows[i].c, rows[i].pay));
      offset = 6'd10; loop_en = 1'b0;
      interval = 16'(rows[i].intv); mask = rows[i].msk;
      clear_tabs();
      for (int r = 0; r < MAXH; r++) busy_tab[r] = rows[i].bsy;
      run_scenario(rows[i].t);
      check($sformatf("row%0d_valid", i), 64'(valid_o), 64'(rows[i].ev));
      check($sformatf("row%0d_data", i), 64'(data_o), 64'(rows[i].ed));
      check($sformatf("row%0d_err", i), 64'(busy_err_o), 64'(rows[i].ee));
      check($sformatf("row%0d_done", i), 64'(done_o), 64'(1));
    end

    // Ten words, one-shot, 100-cycle slots
    do_reset();
    for (int k = 0; k < 10; k++) write_word(k, mkw(k == 9, 0, 0, 24'(k)));
    offset = '0; loop_en = 1'b0; interval = 16'd100; mask = 3'b111;
    clear_tabs();
    run_scenario(1010);
    for (int k = 1; k < 10 && k < obs_q.size(); k++) begin
      check($sformatf("gap100_%0d", k), 64'(obs_q[k].t - obs_q[k-1].t), 64'(100));
    end
    @(negedge clk); enb = 1'b0;
    @(negedge clk);
    check("done_clear", 64'(done_o), 64'(0));

    // Same words looping from offset 5
    do_reset();
    offset = 6'd5; loop_en = 1'b1;
    run_scenario(2000);

    // Held word: H=3 on word 2 with minimum slot period
    do_reset();
    for (int k = 0; k < 4; k++) write_word(k, mkw(k == 3, (k == 2) ? 3 : 0, 0, 24'(16'hA00 + k)));
    offset = '0; loop_en = 1'b0; interval = 16'd2;
    run_scenario(40);
    if (obs_q.size() >= 3) check("held_gap", 64'(obs_q[2].t - obs_q[1].t), 64'(16));

    // Busy on the second slot, then clear the error count
    do_reset();
    for (int k = 0; k < 4; k++) write_word(k, mkw(k == 3, 0, 0, 24'(24'hB00 + k)));
    interval = 16'd10;
    clear_tabs();
    busy_tab[19] = 1'b1;
    run_scenario(32);
    check("busy_err_one", 64'(busy_err_o), 64'(1));
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("busy_err_cleared", 64'(busy_err_o), 64'(0));

    // Address wrap from DEPTH-2
    do_reset();
    clear_tabs();
    write_word(62, mkw(1'b0, 0, 1, 24'h000062));
    write_word(63, mkw(1'b0, 0, 1, 24'h000063));
    write_word(0,  mkw(1'b0, 0, 1, 24'h000100));
    write_word(1,  mkw(1'b1, 0, 1, 24'h000101));
    offset = 6'd62; interval = 16'd4;
    run_scenario(20);
    if (obs_q.size() >= 2) check("wrap_rd_addr", 64'(obs_q[1].a), 64'(0));

    // Disable mid-run: no emits and data held, then restart from offset
    do_reset();
    interval = 16'd8;
    run_scenario(10);
    enb = 1'b0;
    any_valid = 1'b0;
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      if (valid_o != '0) any_valid = 1'b1;
    end
    check("disabled_no_valid", 64'(any_valid), 64'(0));
    check("disabled_data_held", 64'(data_o), 64'(24'h000062));
    start_data = exp_data;
    start_err  = exp_err;
    run_scenario(20);

    // Reset just before a slot, then resume; then the data-lost flag
    do_reset();
    run_scenario(15);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    start_data = '0;
    start_err  = 0;
    run_scenario(20);
    @(negedge clk); lost = 1'b1;
    @(negedge clk); lost = 1'b0;
    check("lost_set", 64'(data_lost_o), 64'(1));
    @(negedge clk); lost = 1'b1; clr = 1'b1;
    @(negedge clk); lost = 1'b0; clr = 1'b0;
    check("lost_set_wins", 64'(data_lost_o), 64'(1));
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("lost_cleared", 64'(data_lost_o), 64'(0));

    // Randomized sequences against the model
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int a = 0; a < DEPTH; a++) begin
        write_word(a, mkw($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 24'($urandom)));
      end
      offset   = AW'($urandom);
      loop_en  = 1'($urandom);
      interval = 16'($urandom_range(0, 9));
      mask     = CH'($urandom);
      for (int r = 0; r < MAXH; r++) begin
        busy_tab[r] = ($urandom_range(0, 3) == 0);
        clr_tab[r]  = ($urandom_range(0, 15) == 0);
      end
      run_scenario(300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
